ranc_param_sequencer: RTL and testbench
=======================================

RANC_PARAM_SEQUENCER -- requirements
Module: ranc_param_sequencer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 5: number of neuron cores receiving per-core parameters.
REQ-002 SHALL have parameter NUM_ENTRIES, default 256: entries per core and entries in the neuron-instruction table.
REQ-003 SHALL have parameter PARAM_W, default 368: width of one core parameter word.
REQ-004 SHALL have parameter INST_W, default 2: width of one neuron-instruction word.
REQ-005 SHALL have the following ports (clock and reset first):
- clk  in  1  core clock.
- reset_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle request to begin a load.
- abort  in  1  single-cycle request to cancel a load.
- inst_valid  in  1  instruction word offered.
- inst_ready  out  1  instruction word accepted when high together with inst_valid.
- inst_data  in  INST_W  instruction word.
- param_valid  in  1  parameter word offered.
- param_ready  out  1  parameter word accepted when high together with param_valid.
- param_data  in  PARAM_W  parameter word.
- neuron_inst_wen  out  1  instruction-table write strobe.
- neuron_inst_address  out  clog2(NUM_ENTRIES)  instruction-table write address.
- neuron_inst_data  out  INST_W  instruction-table write data.
- core_param_wen  out  NUM_CORES  one-hot per-core parameter write strobe.
- core_param_address  out  clog2(NUM_ENTRIES)  parameter write address.
- core_param_data  out  PARAM_W  parameter write data.
- core_idx  out  clog2(NUM_CORES)  core currently being loaded.
- busy  out  1  load in progress.
- done  out  1  last load completed.

Function
REQ-006 SHALL implement the states IDLE, LOAD_INST, LOAD_PARAM and DONE.
REQ-007 SHALL move from IDLE or DONE to LOAD_INST on start, clearing the entry counter and core_idx and deasserting done.
REQ-008 SHALL, in LOAD_INST, drive inst_ready=1 and param_ready=0; in LOAD_PARAM, inst_ready=0 and param_ready=1; in other states both 0.
REQ-009 SHALL, on each accepted instruction word, assert neuron_inst_wen for exactly one cycle in the next cycle, with address equal to the entry count and data equal to the accepted word (latency 1).
REQ-010 SHALL, on each accepted parameter word, assert core_param_wen[core_idx] alone for exactly one cycle in the next cycle, with address equal to the entry count and data equal to the accepted word (latency 1).
REQ-011 SHALL increment the entry counter per accepted word and wrap it from NUM_ENTRIES-1 to 0.
REQ-012 SHALL go from LOAD_INST to LOAD_PARAM with core_idx=0 after accepting instruction entry NUM_ENTRIES-1.
REQ-013 SHALL, after accepting parameter entry NUM_ENTRIES-1, increment core_idx when core_idx<NUM_CORES-1, else go to DONE.
REQ-014 SHALL, on the final write strobe, write to the outgoing core index; core_idx updates on the cycle after acceptance.
REQ-015 SHALL hold done=1 in DONE until the next start or reset; busy=1 exactly in LOAD_INST and LOAD_PARAM.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL, on abort while busy, return to IDLE next cycle, clear counters, leave done=0, and emit no strobe for a word offered in the abort cycle.
REQ-018 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-019 SHALL allow back-to-back acceptance of one word per cycle; gaps in the valid signal SHALL stall the counter without producing strobes.
REQ-020 SHALL hold address and data outputs stable when the write strobes are low.

Reset
REQ-021 SHALL, on reset_n low, enter IDLE and drive all strobes 0, addresses 0, data 0, core_idx 0, busy 0, done 0, and both ready outputs 0.
REQ-022 SHALL treat reset during a load like abort and require a new start afterwards.

Structure
REQ-023 SHALL place the state encoding and the default NUM_CORES, NUM_ENTRIES, PARAM_W and INST_W constants in the shared ranc_pkg package.
REQ-024 SHALL be a single module with no sub-modules; the one-hot decode of core_idx is inline.

Verification
REQ-025 Full load, NUM_ENTRIES=256, NUM_CORES=5, continuous valid -> 256 instruction strobes, then 1280 parameter strobes (256 per core, in order 0..4), then done=1 at cycle 1537 after the first acceptance.
REQ-026 Core boundary: core 1 address 255 with data 0xAB -> core_param_wen=5'b00010 with address 255, then core_idx=2, and the next word writes core 2 at address 0.
REQ-027 Random valid gaps of 0-3 cycles -> strobe count unchanged and addresses contiguous with no duplicates.
REQ-028 Abort at core 3 address 100 -> busy=0 the next cycle, no further strobes, done=0; a following start reloads from instruction address 0.
REQ-029 Start during LOAD_PARAM -> ignored, with no counter change.
REQ-030 Reset asserted mid LOAD_INST -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/ranc_pkg.sv
// Shared constants for the RANC parameter loader: default geometry and the
// sequencer state encoding.
package ranc_pkg;

  localparam int RANC_NUM_CORES   = 5;
  localparam int RANC_NUM_ENTRIES = 256;
  localparam int RANC_PARAM_W     = 368;
  localparam int RANC_INST_W      = 2;

  localparam int SEQ_STATE_W = 2;

  localparam logic [SEQ_STATE_W-1:0] SEQ_IDLE       = 2'd0;
  localparam logic [SEQ_STATE_W-1:0] SEQ_LOAD_INST  = 2'd1;
  localparam logic [SEQ_STATE_W-1:0] SEQ_LOAD_PARAM = 2'd2;
  localparam logic [SEQ_STATE_W-1:0] SEQ_DONE       = 2'd3;

endpackage

// File: rtl/ranc_param_sequencer.sv
// Streams one neuron-instruction table, then NUM_ENTRIES parameter words per
// core, into the RANC memories with registered one-cycle write strobes.
module ranc_param_sequencer
  import ranc_pkg::*;
#(
  parameter int NUM_CORES   = RANC_NUM_CORES,
  parameter int NUM_ENTRIES = RANC_NUM_ENTRIES,
  parameter int PARAM_W     = RANC_PARAM_W,
  parameter int INST_W      = RANC_INST_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           inst_valid,
  output logic                           inst_ready,
  input  logic [INST_W-1:0]              inst_data,
  input  logic                           param_valid,
  output logic                           param_ready,
  input  logic [PARAM_W-1:0]             param_data,
  output logic                           neuron_inst_wen,
  output logic [$clog2(NUM_ENTRIES)-1:0] neuron_inst_address,
  output logic [INST_W-1:0]              neuron_inst_data,
  output logic [NUM_CORES-1:0]           core_param_wen,
  output logic [$clog2(NUM_ENTRIES)-1:0] core_param_address,
  output logic [PARAM_W-1:0]             core_param_data,
  output logic [$clog2(NUM_CORES)-1:0]   core_idx,
  output logic                           busy,
  output logic                           done
);

  localparam int ENTRY_W = $clog2(NUM_ENTRIES);
  localparam int CORE_W  = $clog2(NUM_CORES);
  localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(NUM_ENTRIES - 1);
  localparam logic [CORE_W-1:0]  LAST_CORE  = CORE_W'(NUM_CORES - 1);

  // Handshake: a word transfers on a rising edge where valid and ready are
  // both high; ready depends only on state, never on valid.

  logic [SEQ_STATE_W-1:0] state_q, state_d;
  logic [ENTRY_W-1:0]     entry_q, entry_d;
  logic [CORE_W-1:0]      core_idx_q, core_idx_d;

  logic                   inst_wen_q, inst_wen_d;
  logic [ENTRY_W-1:0]     inst_addr_q, inst_addr_d;
  logic [INST_W-1:0]      inst_data_q, inst_data_d;
  logic [NUM_CORES-1:0]   param_wen_q, param_wen_d;
  logic [ENTRY_W-1:0]     param_addr_q, param_addr_d;
  logic [PARAM_W-1:0]     param_data_q, param_data_d;

  logic in_inst;
  logic in_param;
  logic inst_acc;
  logic param_acc;
  logic last_entry;

  assign in_inst    = (state_q == SEQ_LOAD_INST);
  assign in_param   = (state_q == SEQ_LOAD_PARAM);
  // A word offered alongside abort is dropped: the load is being torn down.
  assign inst_acc   = in_inst  && inst_valid  && !abort;
  assign param_acc  = in_param && param_valid && !abort;
  assign last_entry = (entry_q == LAST_ENTRY);

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    core_idx_d = core_idx_q;
    case (state_q)
      SEQ_IDLE, SEQ_DONE: begin
        if (start && !abort) begin
          state_d    = SEQ_LOAD_INST;
          entry_d    = '0;
          core_idx_d = '0;
        end
      end
      SEQ_LOAD_INST: begin
        if (abort) begin
          state_d    = SEQ_IDLE;
          entry_d    = '0;
          core_idx_d = '0;
        end else if (inst_acc) begin
          if (last_entry) begin
            state_d    = SEQ_LOAD_PARAM;
            entry_d    = '0;
            core_idx_d = '0;
          end else begin
            entry_d = entry_q + 1'b1;
          end
        end
      end
      SEQ_LOAD_PARAM: begin
        if (abort) begin
          state_d    = SEQ_IDLE;
          entry_d    = '0;
          core_idx_d = '0;
        end else if (param_acc) begin
          if (last_entry) begin
            entry_d = '0;
            if (core_idx_q == LAST_CORE) begin
              state_d = SEQ_DONE;
            end else begin
              core_idx_d = core_idx_q + 1'b1;
            end
          end else begin
            entry_d = entry_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = SEQ_IDLE;
        entry_d    = '0;
        core_idx_d = '0;
      end
    endcase
  end

  // Write ports latch only on acceptance so address/data hold between strobes.
  always_comb begin
    inst_wen_d   = inst_acc;
    inst_addr_d  = inst_acc ? entry_q : inst_addr_q;
    inst_data_d  = inst_acc ? inst_data : inst_data_q;
    param_addr_d = param_acc ? entry_q : param_addr_q;
    param_data_d = param_acc ? param_data : param_data_q;
    param_wen_d  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      param_wen_d[i] = param_acc && (core_idx_q == CORE_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEQ_IDLE;
      entry_q      <= '0;
      core_idx_q   <= '0;
      inst_wen_q   <= 1'b0;
      inst_addr_q  <= '0;
      inst_data_q  <= '0;
      param_wen_q  <= '0;
      param_addr_q <= '0;
      param_data_q <= '0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      core_idx_q   <= core_idx_d;
      inst_wen_q   <= inst_wen_d;
      inst_addr_q  <= inst_addr_d;
      inst_data_q  <= inst_data_d;
      param_wen_q  <= param_wen_d;
      param_addr_q <= param_addr_d;
      param_data_q <= param_data_d;
    end
  end

  assign inst_ready          = in_inst;
  assign param_ready         = in_param;
  assign neuron_inst_wen     = inst_wen_q;
  assign neuron_inst_address = inst_addr_q;
  assign neuron_inst_data    = inst_data_q;
  assign core_param_wen      = param_wen_q;
  assign core_param_address  = param_addr_q;
  assign core_param_data     = param_data_q;
  assign core_idx            = core_idx_q;
  assign busy                = in_inst || in_param;
  assign done                = (state_q == SEQ_DONE);

endmodule

// File: tb/tb_ranc_param_sequencer.sv
// Directed bench for ranc_param_sequencer: drivers push expected write strobes
// into a queue, a negedge monitor pops and compares every strobe it sees.
module tb_ranc_param_sequencer;

  localparam int NC    = 5;
  localparam int NE    = 256;
  localparam int PW    = 368;
  localparam int IW    = 2;
  localparam int AW    = 8;
  localparam int CW    = 3;
  localparam int EXP_W = 1 + CW + AW + PW;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic          inst_valid;
  logic          inst_ready;
  logic [IW-1:0] inst_data;
  logic          param_valid;
  logic          param_ready;
  logic [PW-1:0] param_data;
  logic          neuron_inst_wen;
  logic [AW-1:0] neuron_inst_address;
  logic [IW-1:0] neuron_inst_data;
  logic [NC-1:0] core_param_wen;
  logic [AW-1:0] core_param_address;
  logic [PW-1:0] core_param_data;
  logic [CW-1:0] core_idx;
  logic          busy;
  logic          done;

  ranc_param_sequencer dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .abort               (abort),
    .inst_valid          (inst_valid),
    .inst_ready          (inst_ready),
    .inst_data           (inst_data),
    .param_valid         (param_valid),
    .param_ready         (param_ready),
    .param_data          (param_data),
    .neuron_inst_wen     (neuron_inst_wen),
    .neuron_inst_address (neuron_inst_address),
    .neuron_inst_data    (neuron_inst_data),
    .core_param_wen      (core_param_wen),
    .core_param_address  (core_param_address),
    .core_param_data     (core_param_data),
    .core_idx            (core_idx),
    .busy                (busy),
    .done                (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int vectors;
  int miscompares;
  int strobe_cnt;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  logic [NC-1:0]    mon_oh;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [PW-1:0] pword(input int c, input int a);
    logic [PW-1:0] w;
    if (c == 1 && a == 255) return PW'(8'hAB);
    w = '0;
    w[7:0]     = a[7:0];
    w[15:8]    = c[7:0];
    w[207:200] = ~a[7:0];
    w[367:360] = 8'h5A;
    return w;
  endfunction

  function automatic logic [IW-1:0] iword(input int a);
    return IW'(a ^ (a >> 2));
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (neuron_inst_wen && (core_param_wen != '0))
        check("dual_strobe", PW'(1), PW'(0));
      if (neuron_inst_wen) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          check("inst_unexpected_strobe", PW'(neuron_inst_address), PW'(0) - 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("inst_kind", PW'(0), PW'(mon_e[EXP_W-1]));
          check("inst_addr", PW'(neuron_inst_address), PW'(mon_e[PW+AW-1 -: AW]));
          check("inst_data", PW'(neuron_inst_data), mon_e[PW-1:0]);
        end
      end
      if (core_param_wen != '0) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          check("param_unexpected_strobe", PW'(core_param_wen), PW'(0));
        end else begin
          mon_e  = exp_q.pop_front();
          mon_oh = NC'(1) << mon_e[EXP_W-2 -: CW];
          check("param_kind", PW'(1), PW'(mon_e[EXP_W-1]));
          check("param_wen", PW'(core_param_wen), PW'(mon_oh));
          check("param_addr", PW'(core_param_address), PW'(mon_e[PW+AW-1 -: AW]));
          check("param_data", core_param_data, mon_e[PW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input bit is_param, input int c, input int a);
    int budget;
    budget = 0;
    if (is_param) begin
      param_valid = 1'b1;
      param_data  = pword(c, a);
    end else begin
      inst_valid = 1'b1;
      inst_data  = iword(a);
    end
    while (!(is_param ? param_ready : inst_ready) && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    if (is_param ? param_ready : inst_ready)
      exp_q.push_back({is_param, CW'(c), AW'(a), is_param ? pword(c, a) : PW'(iword(a))});
    else
      check("handshake_timeout", PW'(0), PW'(1));
    @(negedge clk);
    inst_valid  = 1'b0;
    param_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic gap(input bit random_gaps);
    if (random_gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check(name, PW'(exp_q.size()), PW'(0));
  endtask

  task automatic check_reset_outputs;
    check("rst_inst_ready", PW'(inst_ready), PW'(0));
    check("rst_param_ready", PW'(param_ready), PW'(0));
    check("rst_inst_wen", PW'(neuron_inst_wen), PW'(0));
    check("rst_inst_addr", PW'(neuron_inst_address), PW'(0));
    check("rst_inst_data", PW'(neuron_inst_data), PW'(0));
    check("rst_param_wen", PW'(core_param_wen), PW'(0));
    check("rst_param_addr", PW'(core_param_address), PW'(0));
    check("rst_param_data", core_param_data, PW'(0));
    check("rst_core_idx", PW'(core_idx), PW'(0));
    check("rst_busy", PW'(busy), PW'(0));
    check("rst_done", PW'(done), PW'(0));
  endtask

  // Full load; optional random gaps and an ignored start mid parameter load.
  task automatic full_load(input bit random_gaps, input bit poke_start);
    int c0;
    strobe_cnt = 0;
    c0 = cyc;
    for (int a = 0; a < NE; a++) begin
      gap(random_gaps);
      if (a == 0) c0 = cyc;
      send_word(1'b0, 0, a);
    end
    for (int c = 0; c < NC; c++) begin
      for (int a = 0; a < NE; a++) begin
        gap(random_gaps);
        if (a == 0) check("core_idx_at_core_start", PW'(core_idx), PW'(c));
        if (poke_start && c == 0 && a == 10) begin
          pulse_start();
          check("start_ignored_core_idx", PW'(core_idx), PW'(0));
          check("start_ignored_busy", PW'(busy), PW'(1));
          check("start_ignored_param_ready", PW'(param_ready), PW'(1));
        end
        if (c == NC - 1 && a == NE - 1) check("done_before_last", PW'(done), PW'(0));
        send_word(1'b1, c, a);
        if (c == 1 && a == NE - 1) check("core_idx_after_boundary", PW'(core_idx), PW'(2));
      end
    end
    check("done_after_load", PW'(done), PW'(1));
    check("busy_after_load", PW'(busy), PW'(0));
    if (!random_gaps) check("done_cycle", PW'(cyc - c0 + 1), PW'(1537));
    drain("load_queue_empty");
    check("load_strobe_count", PW'(strobe_cnt), PW'(1536));
    check("done_held", PW'(done), PW'(1));
    check("param_ready_in_done", PW'(param_ready), PW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    strobe_cnt  = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    inst_valid  = 1'b0;
    inst_data   = '0;
    param_valid = 1'b0;
    param_data  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    @(negedge clk);

    // continuous full load
    pulse_start();
    check("start_busy", PW'(busy), PW'(1));
    check("start_inst_ready", PW'(inst_ready), PW'(1));
    check("start_param_ready", PW'(param_ready), PW'(0));
    full_load(1'b0, 1'b0);

    // restart from DONE with random gaps and a start during LOAD_PARAM
    pulse_start();
    check("restart_done_cleared", PW'(done), PW'(0));
    check("restart_busy", PW'(busy), PW'(1));
    full_load(1'b1, 1'b1);

    // abort at core 3 address 100
    pulse_start();
    for (int a = 0; a < NE; a++) send_word(1'b0, 0, a);
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < NE; a++) begin
        if (c == 3 && a == 100) break;
        send_word(1'b1, c, a);
      end
    end
    abort       = 1'b1;
    start       = 1'b1;
    param_valid = 1'b1;
    param_data  = pword(3, 100);
    @(negedge clk);
    abort       = 1'b0;
    start       = 1'b0;
    param_valid = 1'b0;
    check("abort_busy", PW'(busy), PW'(0));
    check("abort_done", PW'(done), PW'(0));
    check("abort_param_ready", PW'(param_ready), PW'(0));
    check("abort_core_idx", PW'(core_idx), PW'(0));
    drain("abort_queue_empty");

    // reload after abort starts from instruction address 0
    pulse_start();
    check("reload_inst_ready", PW'(inst_ready), PW'(1));
    for (int a = 0; a < 4; a++) send_word(1'b0, 0, a);
    drain("reload_queue_empty");

    // asynchronous reset mid LOAD_INST, with a word in flight
    inst_valid = 1'b1;
    inst_data  = iword(4);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_inst_ready", PW'(inst_ready), PW'(0));
    check("post_reset_busy", PW'(busy), PW'(0));
    inst_valid = 1'b0;
    drain("post_reset_queue_empty");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
